fsm_responder: RTL and testbench



---
 rtl/fsm_responder_if.sv | 38 +++
 rtl/fsm_responder.sv | 99 +++++++++
 tb/tb_fsm_responder.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fsm_responder_if.sv
// Controller/responder handshake bundle. DONE_CNT and the CW parameter exist only when
// RESPONDER_STATUS_EN is defined.
interface fsm_responder_if
`ifdef RESPONDER_STATUS_EN
  #(parameter int unsigned CW = 8)
`endif
  ;
    logic RESET;
    logic START;
    logic READY;
    logic BUSY;
    logic ERR;
`ifdef RESPONDER_STATUS_EN
    logic [CW-1:0] DONE_CNT;
`endif

    modport master (
        output RESET,
        output START,
        input  READY,
        input  BUSY,
        input  ERR
`ifdef RESPONDER_STATUS_EN
        , input DONE_CNT
`endif
    );

    modport slave (
        input  RESET,
        input  START,
        output READY,
        output BUSY,
        output ERR
`ifdef RESPONDER_STATUS_EN
        , output DONE_CNT
`endif
    );
endinterface

// File: rtl/fsm_responder.sv
// Responder FSM: runs a DELAY-cycle job on START, then holds READY until RESET.
// Optional completed-job counter DONE_CNT under RESPONDER_STATUS_EN.
module fsm_responder #(
    parameter int unsigned DELAY = 4,
    parameter int unsigned CW    = 8
) (
    input  logic            CLK,
    input  logic            N_RESET,
    fsm_responder_if.slave  io_bus
);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StCount = 2'b01,
        StRdy   = 2'b10
    } state_e;

    localparam logic [7:0] CntInit = 8'(DELAY - 1);

    if (DELAY < 1 || DELAY > 255 || CW < 1) begin : g_bad_param
        $error("fsm_responder: DELAY must be 1..255 and CW at least 1");
    end

    state_e     r_state, w_state_next;
    logic [7:0] r_cnt, w_cnt_next;
    logic       r_err, w_err_next;

    always_ff @(posedge CLK or negedge N_RESET) begin
        if (!N_RESET) begin
            r_state <= StIdle;
            r_cnt   <= 8'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_err   <= w_err_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_err_next   = r_err;

        case (r_state)
            StIdle: begin
                if (!io_bus.RESET && io_bus.START) begin
                    w_state_next = StCount;
                    w_cnt_next   = CntInit;
                end
            end
            StCount: begin
                if (io_bus.RESET) begin
                    w_state_next = StIdle;
                end else if (r_cnt == 8'd0) begin
                    w_state_next = StRdy;
                end else begin
                    w_cnt_next = r_cnt - 8'd1;
                end
            end
            StRdy: begin
                if (io_bus.RESET) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase

        // A START outside IDLE is a protocol error; RESET always wins over it.
        if (io_bus.RESET) begin
            w_err_next = 1'b0;
        end else if (io_bus.START && (r_state == StCount || r_state == StRdy)) begin
            w_err_next = 1'b1;
        end
    end

    assign io_bus.READY = (r_state == StRdy);
    assign io_bus.BUSY  = (r_state == StCount);
    assign io_bus.ERR   = r_err;

`ifdef RESPONDER_STATUS_EN
    logic          w_job_done;
    logic [CW-1:0] r_done_cnt;

    assign w_job_done = (r_state == StCount) && !io_bus.RESET && (r_cnt == 8'd0);

    // Only N_RESET clears the count; RESET from the controller leaves it alone.
    always_ff @(posedge CLK or negedge N_RESET) begin
        if (!N_RESET) begin
            r_done_cnt <= '0;
        end else if (w_job_done) begin
            r_done_cnt <= r_done_cnt + 1'b1;
        end
    end

    assign io_bus.DONE_CNT = r_done_cnt;
`endif

endmodule

// File: tb/tb_fsm_responder.sv
// Scoreboard bench for fsm_responder: DELAY=4 and DELAY=1 instances, CW=2 for counter wrap.
module tb_fsm_responder;

    logic CLK;
    logic N_RESET;

    typedef struct packed {
        logic rst;
        logic st;
        logic ready;
        logic busy;
        logic err;
    } vec_t;

    int         checks;
    int         failures;
    logic [2:0] exp_q[$];
    logic [2:0] got;
    logic [2:0] exp;
    logic [1:0] exp_done;

`ifdef RESPONDER_STATUS_EN
    fsm_responder_if #(.CW(2)) bus4 ();
    fsm_responder_if #(.CW(2)) bus1 ();
`else
    fsm_responder_if bus4 ();
    fsm_responder_if bus1 ();
`endif

    fsm_responder #(.DELAY(4), .CW(2)) u_dut4 (
        .CLK     (CLK),
        .N_RESET (N_RESET),
        .io_bus  (bus4.slave)
    );

    fsm_responder #(.DELAY(1), .CW(2)) u_dut1 (
        .CLK     (CLK),
        .N_RESET (N_RESET),
        .io_bus  (bus1.slave)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        bus4.RESET = 1'b0;
        bus4.START = 1'b1;
        N_RESET    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(3'b000);
            tick();
            got = {bus4.READY, bus4.BUSY, bus4.ERR};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL reset[%0d] rdy/busy/err got=%b want=%b", i, got, exp);
            end
`ifdef RESPONDER_STATUS_EN
            checks++;
            if (bus4.DONE_CNT !== 2'd0) begin
                failures++;
                $display("FAIL reset_done[%0d] got=%0d want=0", i, bus4.DONE_CNT);
            end
`endif
        end
        bus4.START = 1'b0;
        bus4.RESET = 1'b1;
        N_RESET    = 1'b1;
        exp_q.push_back(3'b000);
        tick();
        got = {bus4.READY, bus4.BUSY, bus4.ERR};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL reset_release rdy/busy/err got=%b want=%b", got, exp);
        end
        exp_done = 2'd0;
    endtask

    task automatic test_nominal();
        vec_t tbl [11] = '{5'b01010, 5'b00010, 5'b00010, 5'b00010, 5'b00100, 5'b00100,
                           5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b10000};
        for (int i = 0; i < 11; i++) begin
            bus4.RESET = tbl[i].rst;
            bus4.START = tbl[i].st;
            exp_q.push_back({tbl[i].ready, tbl[i].busy, tbl[i].err});
            tick();
            got = {bus4.READY, bus4.BUSY, bus4.ERR};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL nominal[%0d] rdy/busy/err got=%b want=%b", i, got, exp);
            end
        end
        exp_done = exp_done + 2'd1;
`ifdef RESPONDER_STATUS_EN
        checks++;
        if (bus4.DONE_CNT !== exp_done) begin
            failures++;
            $display("FAIL nominal_done got=%0d want=%0d", bus4.DONE_CNT, exp_done);
        end
`endif
    endtask

    task automatic test_delay1();
        vec_t tbl [4] = '{5'b01010, 5'b00100, 5'b00100, 5'b10000};
        for (int i = 0; i < 4; i++) begin
            bus1.RESET = tbl[i].rst;
            bus1.START = tbl[i].st;
            exp_q.push_back({tbl[i].ready, tbl[i].busy, tbl[i].err});
            tick();
            got = {bus1.READY, bus1.BUSY, bus1.ERR};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL delay1[%0d] rdy/busy/err got=%b want=%b", i, got, exp);
            end
        end
`ifdef RESPONDER_STATUS_EN
        checks++;
        if (bus1.DONE_CNT !== 2'd1) begin
            failures++;
            $display("FAIL delay1_done got=%0d want=1", bus1.DONE_CNT);
        end
`endif
    endtask

    task automatic test_protocol_err();
        vec_t tbl [7] = '{5'b01010, 5'b00010, 5'b01011, 5'b00011, 5'b00101, 5'b01101,
                          5'b10000};
        for (int i = 0; i < 7; i++) begin
            bus4.RESET = tbl[i].rst;
            bus4.START = tbl[i].st;
            exp_q.push_back({tbl[i].ready, tbl[i].busy, tbl[i].err});
            tick();
            got = {bus4.READY, bus4.BUSY, bus4.ERR};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL protocol_err[%0d] rdy/busy/err got=%b want=%b", i, got, exp);
            end
        end
        exp_done = exp_done + 2'd1;
`ifdef RESPONDER_STATUS_EN
        checks++;
        if (bus4.DONE_CNT !== exp_done) begin
            failures++;
            $display("FAIL protocol_err_done got=%0d want=%0d", bus4.DONE_CNT, exp_done);
        end
`endif
    endtask

    task automatic test_simul_abort();
        vec_t tbl [9] = '{5'b11000, 5'b11000, 5'b01010, 5'b00010, 5'b10000, 5'b00000,
                          5'b00000, 5'b00000, 5'b00000};
        for (int i = 0; i < 9; i++) begin
            bus4.RESET = tbl[i].rst;
            bus4.START = tbl[i].st;
            exp_q.push_back({tbl[i].ready, tbl[i].busy, tbl[i].err});
            tick();
            got = {bus4.READY, bus4.BUSY, bus4.ERR};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL simul_abort[%0d] rdy/busy/err got=%b want=%b", i, got, exp);
            end
        end
`ifdef RESPONDER_STATUS_EN
        checks++;
        if (bus4.DONE_CNT !== exp_done) begin
            failures++;
            $display("FAIL simul_abort_done got=%0d want=%0d", bus4.DONE_CNT, exp_done);
        end
`endif
    endtask

    task automatic test_back_to_back();
        vec_t tbl [14] = '{5'b10000, 5'b01010, 5'b00010, 5'b00010, 5'b00010, 5'b00100,
                           5'b10000, 5'b01010, 5'b00010, 5'b00010, 5'b00010, 5'b00100,
                           5'b00100, 5'b10000};
        for (int i = 0; i < 14; i++) begin
            bus4.RESET = tbl[i].rst;
            bus4.START = tbl[i].st;
            exp_q.push_back({tbl[i].ready, tbl[i].busy, tbl[i].err});
            tick();
            got = {bus4.READY, bus4.BUSY, bus4.ERR};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL back_to_back[%0d] rdy/busy/err got=%b want=%b", i, got, exp);
            end
        end
        exp_done = exp_done + 2'd2;
`ifdef RESPONDER_STATUS_EN
        checks++;
        if (bus4.DONE_CNT !== exp_done) begin
            failures++;
            $display("FAIL back_to_back_done got=%0d want=%0d", bus4.DONE_CNT, exp_done);
        end
`endif
    endtask

    task automatic test_wrap_and_nreset();
        vec_t       job [6] = '{5'b01010, 5'b00010, 5'b00010, 5'b00010, 5'b00100, 5'b10000};
        logic [1:0] seq [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        // Start from a cleared counter.
        N_RESET = 1'b0;
        #2;
        N_RESET = 1'b1;
        bus4.RESET = 1'b1;
        bus4.START = 1'b0;
        tick();
        for (int j = 0; j < 5; j++) begin
            for (int i = 0; i < 6; i++) begin
                bus4.RESET = job[i].rst;
                bus4.START = job[i].st;
                exp_q.push_back({job[i].ready, job[i].busy, job[i].err});
                tick();
                got = {bus4.READY, bus4.BUSY, bus4.ERR};
                exp = exp_q.pop_front();
                checks++;
                if (got !== exp) begin
                    failures++;
                    $display("FAIL wrap_job%0d[%0d] rdy/busy/err got=%b want=%b", j, i, got, exp);
                end
`ifdef RESPONDER_STATUS_EN
                if (i == 4) begin
                    checks++;
                    if (bus4.DONE_CNT !== seq[j]) begin
                        failures++;
                        $display("FAIL wrap_done%0d got=%0d want=%0d", j, bus4.DONE_CNT, seq[j]);
                    end
                end
`endif
            end
        end
        // Abort a running job with N_RESET: effect must be immediate.
        bus4.RESET = 1'b0;
        bus4.START = 1'b1;
        tick();
        bus4.START = 1'b0;
        tick();
        N_RESET = 1'b0;
        #1;
        got = {bus4.READY, bus4.BUSY, bus4.ERR};
        checks++;
        if (got !== 3'b000) begin
            failures++;
            $display("FAIL nreset_abort rdy/busy/err got=%b want=000", got);
        end
`ifdef RESPONDER_STATUS_EN
        checks++;
        if (bus4.DONE_CNT !== 2'd0) begin
            failures++;
            $display("FAIL nreset_abort_done got=%0d want=0", bus4.DONE_CNT);
        end
`endif
        N_RESET = 1'b1;
        exp_q.push_back(3'b000);
        tick();
        tick();
        got = {bus4.READY, bus4.BUSY, bus4.ERR};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL nreset_idle rdy/busy/err got=%b want=%b", got, exp);
        end
        bus4.START = 1'b1;
        exp_q.push_back(3'b010);
        tick();
        got = {bus4.READY, bus4.BUSY, bus4.ERR};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL nreset_restart rdy/busy/err got=%b want=%b", got, exp);
        end
        bus4.START = 1'b0;
        bus4.RESET = 1'b1;
        tick();
    endtask

    initial begin
        CLK        = 1'b0;
        N_RESET    = 1'b0;
        checks     = 0;
        failures   = 0;
        exp_done   = 2'd0;
        bus4.RESET = 1'b0;
        bus4.START = 1'b1;
        bus1.RESET = 1'b1;
        bus1.START = 1'b0;
        test_reset();
        test_nominal();
        test_delay1();
        test_protocol_err();
        test_simul_abort();
        test_back_to_back();
        test_wrap_and_nreset();
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover entries=%0d want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
